walk_response_checker: RTL and testbench



---
 rtl/hack_test_pkg.sv | 34 +++
 rtl/walk_response_checker_pattern_gen.sv | 52 +++++
 rtl/walk_response_checker.sv | 175 +++++++++++++++++
 tb/tb_walk_response_checker.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_test_pkg.sv
// ---------------------------------------------------------------------------
// hack_test_pkg
// Shared definitions for the Hack gate self-test engine.
//   state_t      : checker FSM states (IDLE, DRIVE, WAIT, DONE)
//   cnt_width()  : bit width of counters that must hold 0..width+1
//   walk_pattern : walking-ones vector for a given index
//                  (index 0 gives all zeros, index k>0 gives 1<<(k-1))
// ---------------------------------------------------------------------------
package hack_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest vector walk_pattern can build; callers cast down to their width.
    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] walk_pattern(input int idx, input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        if (idx >= 1 && idx <= width) begin
            v[idx-1] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/walk_response_checker_pattern_gen.sv
// ---------------------------------------------------------------------------
// walk_pattern_gen
// Holds the vector index and the registered stimulus word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : restart at vector 0 (stimulus = all zeros)
//   i_advance   : step to the next vector
//   o_idx       : current vector index (0..WIDTH)
//   o_stim_data : walking-ones pattern for o_idx, stable between steps
//   o_last      : current vector is the final one (idx == WIDTH)
// ---------------------------------------------------------------------------
module walk_pattern_gen
    import hack_test_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_advance,
    output logic [cnt_width(WIDTH)-1:0] o_idx,
    output logic [WIDTH-1:0]            o_stim_data,
    output logic                        o_last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_stim_data;
    logic [CW-1:0]    w_idx_inc;

    assign w_idx_inc = r_idx + CW'(1);

    // The pattern is loaded together with the index so stim_data is already
    // valid in the DRIVE cycle and never changes until the vector completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_stim_data <= '0;
        end else if (i_clear) begin
            r_idx       <= '0;
            r_stim_data <= WIDTH'(walk_pattern(0, WIDTH));
        end else if (i_advance) begin
            r_idx       <= w_idx_inc;
            r_stim_data <= WIDTH'(walk_pattern(int'(w_idx_inc), WIDTH));
        end
    end

    assign o_idx       = r_idx;
    assign o_stim_data = r_stim_data;
    assign o_last      = (r_idx == CW'(WIDTH));

endmodule

// File: rtl/walk_response_checker.sv
// ---------------------------------------------------------------------------
// walk_response_checker
// Drives WIDTH+1 walking-ones vectors to a 16-bit gate under test, accepts
// each response over valid/ready and scores it against the expected value.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a run (honoured in IDLE/DONE only)
//   stim_data    : vector to the unit under test
//   stim_valid   : one-cycle pulse per new vector
//   resp_data    : response from the unit under test
//   resp_valid   : response qualifier
//   resp_ready   : high while waiting for a response
//   busy, done   : run in progress / run finished
//   pass         : no vector failed (meaningful when done)
//   err_count    : failed vectors (saturating)
//   fail_index   : index of the first failed vector
//   fail_data    : response of the first failed vector, 0 if it timed out
//   timeout_flag : at least one vector timed out
// ---------------------------------------------------------------------------
module walk_response_checker
    import hack_test_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter bit INVERT  = 1'b1,
    parameter int TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [WIDTH-1:0]            stim_data,
    output logic                        stim_valid,
    input  logic [WIDTH-1:0]            resp_data,
    input  logic                        resp_valid,
    output logic                        resp_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [cnt_width(WIDTH)-1:0] err_count,
    output logic [cnt_width(WIDTH)-1:0] fail_index,
    output logic [WIDTH-1:0]            fail_data,
    output logic                        timeout_flag
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ERR_MAX = '1;

    state_t           r_state;
    logic [TW-1:0]    r_wait_cnt;
    logic             r_stim_valid;
    logic             r_resp_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CW-1:0]    r_err_count;
    logic [CW-1:0]    r_fail_index;
    logic [WIDTH-1:0] r_fail_data;
    logic             r_timeout_flag;

    logic             w_clear;
    logic             w_advance;
    logic [CW-1:0]    w_idx;
    logic             w_last;
    logic [WIDTH-1:0] w_stim_data;
    logic [WIDTH-1:0] w_expected;
    logic             w_accept;
    logic             w_timeout;
    logic             w_complete;
    logic             w_vec_fail;
    logic [CW-1:0]    w_err_next;

    walk_pattern_gen #(
        .WIDTH(WIDTH)
    ) u_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .o_idx      (w_idx),
        .o_stim_data(w_stim_data),
        .o_last     (w_last)
    );

    // stim_data always equals pattern(idx), so the expected word is derived
    // from it rather than recomputing the pattern.
    assign w_expected = INVERT ? ~w_stim_data : w_stim_data;

    // r_resp_ready is only ever high in WAIT, so it qualifies the handshake.
    assign w_accept   = r_resp_ready && resp_valid;
    // A response on the last allowed cycle takes priority over the timeout.
    assign w_timeout  = (r_state == WAIT) && !resp_valid
                        && (r_wait_cnt == TW'(TIMEOUT - 1));
    assign w_complete = w_accept || w_timeout;
    assign w_vec_fail = w_timeout || (w_accept && (resp_data != w_expected));
    assign w_err_next = (w_vec_fail && (r_err_count != ERR_MAX))
                        ? r_err_count + CW'(1) : r_err_count;

    assign w_clear    = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_advance  = w_complete && !w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_wait_cnt     <= '0;
            r_stim_valid   <= 1'b0;
            r_resp_ready   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_err_count    <= '0;
            r_fail_index   <= '0;
            r_fail_data    <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state        <= DRIVE;
                        r_stim_valid   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_pass         <= 1'b0;
                        r_err_count    <= '0;
                        r_fail_index   <= '0;
                        r_fail_data    <= '0;
                        r_timeout_flag <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_state      <= WAIT;
                    r_stim_valid <= 1'b0;
                    r_resp_ready <= 1'b1;
                    r_wait_cnt   <= '0;
                end
                WAIT: begin
                    if (w_complete) begin
                        r_err_count  <= w_err_next;
                        r_resp_ready <= 1'b0;
                        if (w_timeout) begin
                            r_timeout_flag <= 1'b1;
                        end
                        // Only the first failure of a run is captured.
                        if (w_vec_fail && (r_err_count == '0)) begin
                            r_fail_index <= w_idx;
                            r_fail_data  <= w_accept ? resp_data : '0;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_state      <= DRIVE;
                            r_stim_valid <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stim_data    = w_stim_data;
    assign stim_valid   = r_stim_valid;
    assign resp_ready   = r_resp_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err_count;
    assign fail_index   = r_fail_index;
    assign fail_data    = r_fail_data;
    assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_walk_response_checker.sv
// ---------------------------------------------------------------------------
// tb_walk_response_checker
// Two checkers (INVERT=1 and INVERT=0) share one programmable responder.
// Each vector k gets a response delay (WAIT cycles until resp_valid) and a
// response word; a reference model scores the run from the same tables.
// ---------------------------------------------------------------------------
module tb_walk_response_checker;

    localparam int W  = 16;
    localparam int TO = 8;
    localparam int CW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic         resp_valid = 1'b0;
    logic [W-1:0] resp_data  = '0;

    logic [W-1:0]  stim_data, fail_data, id_stim_data, id_fail_data;
    logic          stim_valid, resp_ready, busy, done, pass, timeout_flag;
    logic          id_stim_valid, id_resp_ready, id_busy, id_done, id_pass, id_timeout_flag;
    logic [CW-1:0] err_count, fail_index, id_err_count, id_fail_index;

    walk_response_checker #(.WIDTH(W), .INVERT(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .stim_data(stim_data), .stim_valid(stim_valid),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_index(fail_index),
        .fail_data(fail_data), .timeout_flag(timeout_flag)
    );

    walk_response_checker #(.WIDTH(W), .INVERT(1'b0), .TIMEOUT(TO)) dut_id (
        .clk(clk), .rst_n(rst_n), .start(start),
        .stim_data(id_stim_data), .stim_valid(id_stim_valid),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(id_resp_ready),
        .busy(id_busy), .done(id_done), .pass(id_pass),
        .err_count(id_err_count), .fail_index(id_fail_index),
        .fail_data(id_fail_data), .timeout_flag(id_timeout_flag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Responder programme and observation log.
    int           delay [0:W];
    logic [W-1:0] rdata [0:W];
    logic [W-1:0] seen  [0:31];
    int           nseen  = 0;
    bit           hold   = 1'b0;
    bit           active = 1'b0;
    int           cur    = 0;
    int           wcnt   = 0;

    function automatic logic [W-1:0] pat(input int k);
        logic [W-1:0] one;
        one = 1;
        return (k == 0) ? '0 : (one << (k - 1));
    endfunction

    // Responder: changes only on the falling edge.
    always @(negedge clk) begin
        if (start && !busy) nseen = 0;
        if (!rst_n) begin
            active     = 1'b0;
            resp_valid = 1'b0;
        end else if (hold) begin
            resp_valid = 1'b1;
            resp_data  = ~stim_data;
            if (stim_valid) begin
                if (nseen < 32) seen[nseen] = stim_data;
                nseen++;
            end
        end else if (stim_valid) begin
            if (nseen < 32) seen[nseen] = stim_data;
            cur        = nseen;
            nseen++;
            active     = 1'b1;
            wcnt       = 0;
            resp_valid = 1'b0;
        end else if (active) begin
            wcnt++;
            if (cur <= W && wcnt == delay[cur]) begin
                resp_valid = 1'b1;
                resp_data  = rdata[cur];
                active     = 1'b0;
            end else begin
                resp_valid = 1'b0;
            end
        end else begin
            resp_valid = 1'b0;
        end
    end

    // Reference: score each vector from its delay and response word.
    // res = {pass, err_count, fail_index, fail_data, timeout_flag}
    task automatic model(input bit inv, output logic [27:0] res, output int cyc);
        int err, first;
        logic [W-1:0] fd, e;
        bit to;
        err = 0; first = -1; fd = '0; to = 1'b0; cyc = 0;
        for (int k = 0; k <= W; k++) begin
            e = inv ? ~pat(k) : pat(k);
            if (delay[k] <= TO) begin
                cyc += 1 + delay[k];
                if (rdata[k] !== e) begin
                    if (first < 0) begin first = k; fd = rdata[k]; end
                    err++;
                end
            end else begin
                cyc += 1 + TO;
                to = 1'b1;
                if (first < 0) begin first = k; fd = '0; end
                err++;
            end
        end
        if (err > 31) err = 31;
        res = {err == 0, 5'(err), 5'((first < 0) ? 0 : first), fd, to};
    endtask

    task automatic program_inverter();
        for (int k = 0; k <= W; k++) begin
            delay[k] = 1;
            rdata[k] = ~pat(k);
        end
    endtask

    // Start a run and count edges after the start edge until done is seen.
    task automatic do_run(input bit rand_start, output int n);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            start = (rand_start && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({stim_data, stim_valid, resp_ready, busy, done, pass, err_count, fail_index, fail_data, timeout_flag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got stim=%h busy=%b done=%b err=%0d, required all zero", stim_data, busy, done, err_count);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({stim_valid, resp_ready, busy, done, pass, err_count, id_busy, id_done} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b ready=%b, required 0", busy, done, resp_ready);
        end
        $display("reset: idle outputs checked");
    endtask

    task automatic test_ideal_inverter();
        logic [27:0] e1, e0;
        int c1, c0, n;
        program_inverter();
        model(1'b1, e1, c1);
        model(1'b0, e0, c0);
        do_run(1'b0, n);
        n_cmp++;
        if (n !== c1 || n !== 34) begin
            n_bad++;
            $display("FAIL ideal_latency: got done after edge %0d, required %0d", n, c1);
        end
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL ideal_results {pass,err,idx,data,to}: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        n_cmp++;
        if ({id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag} !== e0) begin
            n_bad++;
            $display("FAIL ideal_id_results: got %h required %h", {id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag}, e0);
        end
        n_cmp++;
        if (nseen !== W + 1) begin
            n_bad++;
            $display("FAIL stim_count: got %0d vectors, required %0d", nseen, W + 1);
        end
        for (int k = 0; k <= W; k++) begin
            n_cmp++;
            if (seen[k] !== pat(k)) begin
                n_bad++;
                $display("FAIL stim_walk[%0d]: got %h required %h", k, seen[k], pat(k));
            end
        end
        $display("ideal inverter: cycles=%0d pass=%b err=%0d", n, pass, err_count);
    endtask

    task automatic test_stuck_bit5();
        logic [27:0] e1;
        int c1, n;
        program_inverter();
        for (int k = 0; k <= W; k++) rdata[k] = rdata[k] & 16'hFFDF;
        model(1'b1, e1, c1);
        do_run(1'b0, n);
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1 || err_count !== 5'd16) begin
            n_bad++;
            $display("FAIL stuck_results {pass,err,idx,data,to}: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        $display("stuck bit5: err=%0d idx=%0d data=%h", err_count, fail_index, fail_data);
    endtask

    task automatic test_identity();
        logic [27:0] e1, e0;
        int c1, c0, n;
        for (int k = 0; k <= W; k++) begin
            delay[k] = 1;
            rdata[k] = pat(k);
        end
        model(1'b1, e1, c1);
        model(1'b0, e0, c0);
        do_run(1'b0, n);
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL identity_inv_results: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        n_cmp++;
        if ({id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag} !== e0 || id_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL identity_buf_results: got %h required %h", {id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag}, e0);
        end
        $display("identity: inv err=%0d, buf pass=%b", err_count, id_pass);
    endtask

    task automatic test_timeout();
        logic [27:0] e1;
        int c1, n;
        program_inverter();
        for (int k = 0; k <= W; k++) delay[k] = 99;
        model(1'b1, e1, c1);
        do_run(1'b0, n);
        n_cmp++;
        if (n !== c1 || n !== 153) begin
            n_bad++;
            $display("FAIL timeout_latency: got done after edge %0d, required %0d", n, c1);
        end
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL timeout_results: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        $display("no responder: cycles=%0d err=%0d to=%b", n, err_count, timeout_flag);
    endtask

    // Every response lands on the last allowed WAIT cycle except vector 3.
    task automatic test_timeout_boundary();
        logic [27:0] e1;
        int c1, n;
        program_inverter();
        for (int k = 0; k <= W; k++) delay[k] = TO;
        delay[3] = TO + 1;
        model(1'b1, e1, c1);
        do_run(1'b0, n);
        n_cmp++;
        if (n !== c1) begin
            n_bad++;
            $display("FAIL boundary_latency: got done after edge %0d, required %0d", n, c1);
        end
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL boundary_results: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        $display("timeout boundary: err=%0d idx=%0d to=%b", err_count, fail_index, timeout_flag);
    endtask

    task automatic test_held_valid();
        logic [27:0] e1;
        int c1, n;
        program_inverter();
        model(1'b1, e1, c1);
        hold = 1'b1;
        do_run(1'b1, n);
        hold = 1'b0;
        n_cmp++;
        if (n !== c1) begin
            n_bad++;
            $display("FAIL held_latency: got done after edge %0d, required %0d", n, c1);
        end
        n_cmp++;
        if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL held_results: got %h required %h", {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
        end
        n_cmp++;
        if (nseen !== W + 1) begin
            n_bad++;
            $display("FAIL held_vector_count: got %0d, required %0d", nseen, W + 1);
        end
        $display("held valid + start noise: cycles=%0d pass=%b", n, pass);
    endtask

    task automatic test_reset_mid_run();
        logic [27:0] e1;
        int c1, n, g;
        program_inverter();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        g = 0;
        while (!(nseen == 10 && resp_ready) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        n_cmp++;
        if (g >= 200) begin
            n_bad++;
            $display("FAIL reach_idx9_wait: got no WAIT at idx 9 within %0d cycles, required it", g);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stim_data, stim_valid, resp_ready, busy, done, pass, err_count, fail_index, fail_data, timeout_flag} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got stim=%h ready=%b busy=%b err=%0d, required all zero", stim_data, resp_ready, busy, err_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({stim_valid, busy, done, resp_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_after_abort: got busy=%b done=%b, required 0", busy, done);
        end
        model(1'b1, e1, c1);
        do_run(1'b0, n);
        n_cmp++;
        if (n !== c1 || {pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
            n_bad++;
            $display("FAIL rerun_after_abort: got cycles %0d res %h, required %0d %h", n, {pass, err_count, fail_index, fail_data, timeout_flag}, c1, e1);
        end
        $display("reset mid-run: rerun cycles=%0d pass=%b", n, pass);
    endtask

    task automatic test_random();
        logic [27:0] e1, e0;
        int c1, c0, n;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k <= W; k++) begin
                delay[k] = $urandom_range(1, TO + 2);
                rdata[k] = ~pat(k);
                if ($urandom_range(0, 3) == 0) rdata[k] = rdata[k] ^ W'($urandom_range(1, 65535));
            end
            model(1'b1, e1, c1);
            model(1'b0, e0, c0);
            do_run(1'b0, n);
            n_cmp++;
            if (n !== c1) begin
                n_bad++;
                $display("FAIL random%0d_latency: got done after edge %0d, required %0d", r, n, c1);
            end
            n_cmp++;
            if ({pass, err_count, fail_index, fail_data, timeout_flag} !== e1) begin
                n_bad++;
                $display("FAIL random%0d_inv_results: got %h required %h", r, {pass, err_count, fail_index, fail_data, timeout_flag}, e1);
            end
            n_cmp++;
            if ({id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag} !== e0) begin
                n_bad++;
                $display("FAIL random%0d_buf_results: got %h required %h", r, {id_pass, id_err_count, id_fail_index, id_fail_data, id_timeout_flag}, e0);
            end
            $display("random run %0d: cycles=%0d err=%0d to=%b", r, n, err_count, timeout_flag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_ideal_inverter();
        test_stuck_bit5();
        test_identity();
        test_timeout();
        test_timeout_boundary();
        test_held_valid();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
